// File: rtl/au_pkg.sv
// ----------------------------------------------------------------------------
// au_pkg
// Shared types for the sequential arithmetic unit.
//   au_op_e    : operation code as presented on the op port
//   au_state_e : controller states, with fixed encodings
// ----------------------------------------------------------------------------
package au_pkg;

    typedef enum logic [1:0] {
        AU_ADD = 2'b00,
        AU_SUB = 2'b01,
        AU_MUL = 2'b10,
        AU_DIV = 2'b11
    } au_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_DONE   = 3'd4
    } au_state_e;

endpackage

// File: rtl/au_seq_nb_if.sv
// ----------------------------------------------------------------------------
// au_seq_nb_if
// Request/result bundle of the arithmetic unit.
//   master : drives start/op/a/b, observes busy/done and the results
//   slave  : the arithmetic unit itself
// ----------------------------------------------------------------------------
interface au_seq_nb_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, s, hi, lo, zero, carry, ovf, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, s, hi, lo, zero, carry, ovf, dbz
    );

endinterface

// File: rtl/au_addsub_nb.sv
// ----------------------------------------------------------------------------
// au_addsub_nb
// Combinational WIDTH-bit adder/subtractor shared by every datapath step.
//   x, y : operands
//   sub  : 1 = x - y (two's complement), 0 = x + y
//   sum  : WIDTH-bit result
//   cout : carry-out (for subtraction: 1 means no borrow, x >= y unsigned)
//   ovf  : signed overflow
// ----------------------------------------------------------------------------
module au_addsub_nb #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   full;

    assign y_eff = y ^ {WIDTH{sub}};
    assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    // Overflow: both effective operands share a sign the result does not.
    assign ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/au_seq_nb.sv
// ----------------------------------------------------------------------------
// au_seq_nb
// Multi-cycle arithmetic unit: ADD, SUB (1 cycle), unsigned MULT (shift-add)
// and unsigned DIV (restoring), both WIDTH iterations plus a writeback cycle.
//   clk   : clock
//   rst_n : asynchronous reset, active high (aborts any operation)
//   bus   : slave side of au_seq_nb_if (start/op/a/b in; busy/done/results out)
// WIDTH is legal from 4 to 64; CNT_W is derived and must not be overridden.
// ----------------------------------------------------------------------------
module au_seq_nb
    import au_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    au_seq_nb_if.slave   bus
);

    // The counter walks 0..WIDTH-1 through the iterations; the value WIDTH
    // marks the cycle in which the working registers are copied to the outputs.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    au_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    au_op_e           op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Working pair: MULT {hi_r, lo_r}, DIV {R, Q}. lo_w starts as operand a,
    // so it also serves as the ADD/SUB left operand and the DIV-by-zero hi.
    logic [WIDTH-1:0] hw_q, hw_d;
    logic [WIDTH-1:0] lw_q, lw_d;
    // Visible results, only touched when an operation reaches DONE.
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_sub;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    logic [WIDTH:0]   mul_acc;
    logic [WIDTH-1:0] rem_sh;
    logic             div_ok;

    au_addsub_nb #(.WIDTH(WIDTH)) u_addsub (
        .x    (add_x),
        .y    (add_y),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Low WIDTH bits of the remainder after the {R,Q} left shift; the bit
    // shifted out of hw_q is R[WIDTH], which the trial subtract must honour.
    assign rem_sh  = {hw_q[WIDTH-2:0], lw_q[WIDTH-1]};
    // Trial R-b is non-negative if R[WIDTH] was set (R >= 2^WIDTH > b) or the
    // WIDTH-bit subtract did not borrow. R < 2b always, so the difference
    // fits back into WIDTH bits.
    assign div_ok  = hw_q[WIDTH-1] | add_cout;
    assign mul_acc = lw_q[0] ? {add_cout, add_sum} : {1'b0, hw_q};

    always_comb begin
        add_x   = lw_q;
        add_y   = b_q;
        add_sub = 1'b0;
        case (state_q)
            S_ADDSUB: add_sub = (op_q == AU_SUB);
            S_MUL:    add_x   = hw_q;
            S_DIV: begin
                add_x   = rem_sh;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        hw_d    = hw_q;
        lw_d    = lw_q;
        s_d     = s_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = au_op_e'(bus.op);
                    b_d   = bus.b;
                    hw_d  = '0;
                    lw_d  = bus.a;
                    cnt_d = '0;
                    case (au_op_e'(bus.op))
                        AU_ADD, AU_SUB: state_d = S_ADDSUB;
                        AU_MUL:         state_d = S_MUL;
                        default:        state_d = S_DIV;
                    endcase
                end
            end
            S_ADDSUB: begin
                s_d     = add_sum;
                carry_d = add_cout;
                ovf_d   = add_ovf;
                zero_d  = (add_sum == '0);
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    hi_d    = hw_q;
                    lo_d    = lw_q;
                    zero_d  = (hw_q == '0) && (lw_q == '0);
                    dbz_d   = 1'b0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    hw_d  = mul_acc[WIDTH:1];
                    lw_d  = {mul_acc[0], lw_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (b_q == '0) begin
                    hi_d    = lw_q;
                    lo_d    = '1;
                    zero_d  = 1'b0;
                    dbz_d   = 1'b1;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d    = hw_q;
                    lo_d    = lw_q;
                    zero_d  = (lw_q == '0);
                    dbz_d   = 1'b0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    hw_d  = div_ok ? add_sum : rem_sh;
                    lw_d  = {lw_q[WIDTH-2:0], div_ok};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= AU_ADD;
            b_q     <= '0;
            hw_q    <= '0;
            lw_q    <= '0;
            s_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hw_q    <= hw_d;
            lw_q    <= lw_d;
            s_q     <= s_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.s     = s_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
    assign bus.ovf   = ovf_q;
    assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_au_seq_nb.sv
// ----------------------------------------------------------------------------
// tb_au_seq_nb
// Directed bench for au_seq_nb with a 32-bit and an 8-bit instance.
// Expected results come from an arithmetic reference model, are queued when
// an operation is issued and compared when the unit raises done.
// ----------------------------------------------------------------------------
module tb_au_seq_nb;

    typedef struct packed {
        logic [31:0] lat;
        logic [63:0] s;
        logic [63:0] hi;
        logic [63:0] lo;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    au_seq_nb_if #(.WIDTH(32)) bus32 ();
    au_seq_nb_if #(.WIDTH(8))  bus8 ();

    au_seq_nb #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    au_seq_nb #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t st32;
    exp_t st8;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic drive(input bit w8, input logic st, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            bus8.start = st;
            bus8.op    = op;
            bus8.a     = a[7:0];
            bus8.b     = b[7:0];
        end else begin
            bus32.start = st;
            bus32.op    = op;
            bus32.a     = a[31:0];
            bus32.b     = b[31:0];
        end
    endtask

    function automatic exp_t observe(input bit w8);
        exp_t o;
        o.lat = '0;
        if (w8) begin
            o.s = {56'd0, bus8.s};   o.hi = {56'd0, bus8.hi};  o.lo = {56'd0, bus8.lo};
            o.zero = bus8.zero;      o.carry = bus8.carry;
            o.ovf = bus8.ovf;        o.dbz = bus8.dbz;
        end else begin
            o.s = {32'd0, bus32.s};  o.hi = {32'd0, bus32.hi}; o.lo = {32'd0, bus32.lo};
            o.zero = bus32.zero;     o.carry = bus32.carry;
            o.ovf = bus32.ovf;       o.dbz = bus32.dbz;
        end
        return o;
    endfunction

    function automatic logic obs_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic obs_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    // Reference model: plain wide arithmetic, then the output-update rules.
    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input exp_t prev);
        exp_t        e;
        logic [127:0] mask;
        logic [127:0] full;
        logic [127:0] t;
        logic         sa, sb_, ss;
        e    = prev;
        mask = (128'd1 << w) - 128'd1;
        case (op)
            2'b00, 2'b01: begin
                if (op == 2'b00) full = {64'd0, a} + {64'd0, b};
                else             full = ({64'd0, a} - {64'd0, b}) & mask;
                t       = full & mask;
                e.s     = t[63:0];
                sa      = a[w-1];
                sb_     = b[w-1];
                ss      = e.s[w-1];
                e.carry = (op == 2'b00) ? full[w] : (a >= b);
                e.ovf   = (op == 2'b00) ? ((sa == sb_) && (ss != sa)) : ((sa != sb_) && (ss != sa));
                e.zero  = (e.s == 64'd0);
                e.dbz   = 1'b0;
                e.lat   = 32'd2;
            end
            2'b10: begin
                full    = {64'd0, a} * {64'd0, b};
                t       = (full >> w) & mask;
                e.hi    = t[63:0];
                t       = full & mask;
                e.lo    = t[63:0];
                e.zero  = (full == 128'd0);
                e.carry = 1'b0;
                e.ovf   = 1'b0;
                e.dbz   = 1'b0;
                e.lat   = 32'(w + 2);
            end
            default: begin
                e.carry = 1'b0;
                e.ovf   = 1'b0;
                if (b == 64'd0) begin
                    e.hi   = a;
                    e.lo   = mask[63:0];
                    e.dbz  = 1'b1;
                    e.zero = 1'b0;
                    e.lat  = 32'd2;
                end else begin
                    e.hi   = a % b;
                    e.lo   = a / b;
                    e.dbz  = 1'b0;
                    e.zero = (e.lo == 64'd0);
                    e.lat  = 32'(w + 2);
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk_cleared(input bit w8, input string tag);
        exp_t o;
        o = observe(w8);
        chk({tag, " busy"},  64'(obs_busy(w8)), 64'd0);
        chk({tag, " done"},  64'(obs_done(w8)), 64'd0);
        chk({tag, " s"},     o.s,  64'd0);
        chk({tag, " hi"},    o.hi, 64'd0);
        chk({tag, " lo"},    o.lo, 64'd0);
        chk({tag, " flags"}, 64'({o.zero, o.carry, o.ovf, o.dbz}), 64'd0);
    endtask

    // Issue one operation, optionally poking start and changing operands
    // while busy, optionally raising start during the DONE cycle.
    task automatic run_op(input bit w8, input logic [1:0] op,
                          input logic [63:0] a_in, input logic [63:0] b_in,
                          input string tag, input bit poke, input bit late_start);
        logic [63:0] a, b;
        exp_t e, o;
        int   n;
        bit   seen;
        a = w8 ? {56'd0, a_in[7:0]} : {32'd0, a_in[31:0]};
        b = w8 ? {56'd0, b_in[7:0]} : {32'd0, b_in[31:0]};
        e = model(w8 ? 8 : 32, op, a, b, w8 ? st8 : st32);
        if (w8) st8 = e; else st32 = e;
        sb.push_back(e);
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(w8, 1'b0, op, ~a, ~b);
        n    = 1;
        seen = 1'b0;
        chk({tag, " busy@1"}, 64'(obs_busy(w8)), 64'd1);
        while (n <= 100) begin
            if (obs_done(w8)) begin
                seen = 1'b1;
                break;
            end
            drive(w8, (poke && n >= 2 && n <= 4), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, " done within budget"}, 64'd0, 64'd1);
            return;
        end
        o = observe(w8);
        chk({tag, " latency"},    64'(n), 64'(e.lat));
        chk({tag, " busy@done"},  64'(obs_busy(w8)), 64'd0);
        chk({tag, " s"},          o.s,  e.s);
        chk({tag, " hi"},         o.hi, e.hi);
        chk({tag, " lo"},         o.lo, e.lo);
        chk({tag, " zero"},       64'(o.zero),  64'(e.zero));
        chk({tag, " carry"},      64'(o.carry), 64'(e.carry));
        chk({tag, " ovf"},        64'(o.ovf),   64'(e.ovf));
        chk({tag, " dbz"},        64'(o.dbz),   64'(e.dbz));
        if (late_start) drive(w8, 1'b1, 2'b00, a, b);
        @(negedge clk);
        drive(w8, 1'b0, 2'b00, a, b);
        chk({tag, " done pulse"}, 64'(obs_done(w8)), 64'd0);
        chk({tag, " idle after"}, 64'(obs_busy(w8)), 64'd0);
        if (late_start) begin
            @(negedge clk);
            chk({tag, " start in DONE ignored"}, 64'(obs_busy(w8) | obs_done(w8)), 64'd0);
        end
        $display("op %s w=%0d op=%0d a=0x%0h b=0x%0h -> s=0x%0h hi=0x%0h lo=0x%0h lat=%0d",
                 tag, w8 ? 8 : 32, op, a, b, o.s, o.hi, o.lo, n);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
        st32 = '0;
        st8  = '0;
        repeat (3) @(negedge clk);
        chk_cleared(1'b0, "reset32");
        chk_cleared(1'b1, "reset8");
        rst_n = 1'b0;

        run_op(1'b0, 2'b00, 64'h7FFFFFFF, 64'h1, "add_ovf", 1'b0, 1'b0);
        run_op(1'b0, 2'b01, 64'd5, 64'd5, "sub_eq", 1'b0, 1'b0);
        run_op(1'b0, 2'b01, 64'd3, 64'd5, "sub_borrow", 1'b0, 1'b0);
        run_op(1'b0, 2'b10, 64'hFFFFFFFF, 64'hFFFFFFFF, "mul_max", 1'b1, 1'b0);
        run_op(1'b0, 2'b10, 64'd0, 64'd7, "mul_zero", 1'b0, 1'b0);
        run_op(1'b0, 2'b11, 64'd100, 64'd7, "div_100_7", 1'b1, 1'b1);
        run_op(1'b0, 2'b11, 64'd9, 64'd0, "div_by_zero", 1'b0, 1'b0);
        run_op(1'b0, 2'b00, 64'hFFFFFFFF, 64'h1, "add_carry", 1'b0, 1'b0);

        // Reset at iteration 10 of a multiply.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 64'h1234, 64'h5678);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (10) @(negedge clk);
        chk("mul busy before reset", 64'(bus32.busy), 64'd1);
        rst_n = 1'b1;
        #1;
        chk_cleared(1'b0, "mid-op reset32");
        chk_cleared(1'b1, "mid-op reset8");
        st32 = '0;
        st8  = '0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n += int'(bus32.done);
        end
        rst_n = 1'b0;
        chk("no done after reset", 64'(n), 64'd0);
        repeat (40) begin
            @(negedge clk);
            n += int'(bus32.done | bus32.busy);
        end
        chk("aborted op stays dead", 64'(n), 64'd0);
        run_op(1'b0, 2'b00, 64'd20, 64'd22, "add_after_reset", 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 2'($urandom_range(0, 3)), {32'd0, $urandom}, {32'd0, $urandom},
                   "rand32", 1'b0, 1'b0);
        end

        run_op(1'b1, 2'b10, 64'hFF, 64'h02, "w8_mul", 1'b1, 1'b0);
        run_op(1'b1, 2'b11, 64'hFF, 64'h10, "w8_div", 1'b0, 1'b0);
        run_op(1'b1, 2'b00, 64'h7F, 64'h01, "w8_add_ovf", 1'b0, 1'b0);
        run_op(1'b1, 2'b01, 64'h80, 64'h01, "w8_sub_ovf", 1'b0, 1'b0);
        run_op(1'b1, 2'b11, 64'h05, 64'h00, "w8_div0", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 2'($urandom_range(0, 3)), {56'd0, 8'($urandom)}, {56'd0, 8'($urandom)},
                   "rand8", 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/au_seq_nb.md
Name: au_seq_nb

Overview:
- Parametrised, multi-cycle arithmetic unit supporting ADD, SUB, unsigned MULT and unsigned DIV on WIDTH-bit operands.
- Uses a start/busy/done handshake. ADD/SUB complete in one cycle; MULT uses an iterative shift-add datapath and DIV a restoring datapath, both taking WIDTH iterations.
- Sits between the register-file read stage and writeback. Results land in s (ADD/SUB) or hi/lo (MULT/DIV).

Parameters:
- WIDTH, 32, operand and result width; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when busy=0
- op  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV; sampled on accept
- a  in  WIDTH  operand A; sampled on accept
- b  in  WIDTH  operand B; sampled on accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- s  out  WIDTH  ADD/SUB result
- hi  out  WIDTH  MULT upper product / DIV remainder
- lo  out  WIDTH  MULT lower product / DIV quotient
- zero  out  1  zero flag of the last result
- carry  out  1  ADD carry-out; SUB no-borrow (a>=b unsigned)
- ovf  out  1  ADD/SUB signed overflow
- dbz  out  1  last DIV had b==0

Behaviour:
- Reset (rst_n=1, any time, including mid-operation): state IDLE, counter 0, all outputs 0. Any in-flight operation is aborted and produces no done.
- Accept: in IDLE, start=1 latches op, a and b. start while busy=1 is ignored with no side effects.
- States:
  - IDLE: on accept go to ADDSUB, MUL or DIV (per op); busy=1 from the next cycle.
  - ADDSUB (1 cycle): s = a + (b ^ {WIDTH{sub}}) + sub, computed WIDTH+1 bits wide. carry = bit WIDTH. ovf = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]). zero = (s==0). Next state DONE.
  - MUL: P = {hi_r, lo_r} initialised to {0, a}. Each cycle: if lo_r[0], hi_r += b, capturing the WIDTH+1-bit sum; then shift {carry, hi_r, lo_r} right by 1. Runs WIDTH cycles, counter 0..WIDTH-1, then DONE. zero = ({hi,lo}==0).
  - DIV: if b==0, skip iteration and go to DONE with hi=a, lo=all-ones, dbz=1, zero=0. Otherwise restoring division with remainder R (WIDTH+1 bits, init 0) and quotient Q=a. Each cycle: shift {R,Q} left by 1, then T=R-b. If T is non-negative, R=T and Q[0]=1; else Q[0]=0. Runs WIDTH cycles, then DONE with hi=R[WIDTH-1:0], lo=Q, zero=(Q==0).
  - DONE: done=1 for exactly this cycle; busy=0 from this cycle. Next state IDLE. A start in the DONE cycle is not accepted; it is seen only from IDLE.
- Latency, accept edge to done high: ADD/SUB 2 cycles; DIV by zero 2 cycles; MULT/DIV WIDTH+2 cycles.
- Outputs hold their last values until the next operation reaches DONE.
  - ADD/SUB updates only s, zero, carry and ovf; it clears dbz.
  - MULT/DIV update only hi, lo, zero and dbz; they clear carry and ovf.
- Operand changes after accept have no effect. All arithmetic is modulo 2^WIDTH except where noted.

Decomposition:
- Package au_pkg:
  - typedef enum logic [1:0] au_op_e {AU_ADD, AU_SUB, AU_MUL, AU_DIV}
  - typedef enum au_state_e {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DONE}
- One sub-module: au_addsub_nb #(WIDTH), a combinational adder/subtractor.
  - Inputs: x, y, sub. Outputs: sum[WIDTH-1:0], cout, ovf.
  - Instanced once and muxed between the ADDSUB, MUL accumulate and DIV trial-subtract steps.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> done 2 cycles after accept; s=0x80000000, ovf=1, carry=0, zero=0.
- SUB 5 - 5 -> s=0, zero=1, carry=1, ovf=0. Then SUB 3 - 5 -> s=0xFFFFFFFE, carry=0.
- MULT 0xFFFFFFFF * 0xFFFFFFFF -> done at cycle 34 after accept; hi=0xFFFFFFFE, lo=0x00000001. Also MULT 0 * 7 -> hi=lo=0, zero=1.
- DIV 100 / 7 -> hi=2, lo=14, dbz=0. DIV 9 / 0 -> done at cycle 2; hi=9, lo=0xFFFFFFFF, dbz=1.
- Start pulses during busy are ignored and operand changes mid-op have no effect. rst_n=1 at iteration 10 of a MULT -> all outputs 0, no done, busy=0; the next ADD runs normally.
- WIDTH=8 instance: MULT 0xFF * 0x02 -> hi=0x01, lo=0xFE, latency 10. DIV 0xFF / 0x10 -> hi=0x0F, lo=0x0F.
